// File: rtl/obc_pkg.sv
// Shared types and sizes for the bit-plane serializer.
// Frame geometry, plane-index width and FSM states.
package obc_pkg;

  localparam int DATA_W = 16;
  localparam int N_PTS  = 16;
  localparam int PIDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/obc_bitplane_shreg.sv
// Frame store with parallel load and registered plane select.
// bits_o[k] is bit sel of sample k of the stored frame.
module obc_bitplane_shreg #(
  parameter int DATA_W = 16,
  parameter int N_PTS  = 16,
  parameter int PW     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_i,
  input  logic [N_PTS*DATA_W-1:0]   data_i,
  input  logic                      adv_i,
  input  logic [PW-1:0]             sel_i,
  output logic [N_PTS-1:0]          bits_o
);

  logic [N_PTS*DATA_W-1:0] frame_q, frame_d;
  logic [N_PTS-1:0]        bits_q, bits_d;

  function automatic logic [N_PTS-1:0] plane(
    input logic [N_PTS*DATA_W-1:0] f,
    input logic [PW-1:0]           p
  );
    logic [N_PTS-1:0]  b;
    logic [DATA_W-1:0] s;
    b = '0;
    for (int k = 0; k < N_PTS; k++) begin
      s    = f[k*DATA_W +: DATA_W];
      b[k] = s[p];
    end
    return b;
  endfunction

  // next frame and next plane slice
  always_comb begin
    frame_d = frame_q;
    bits_d  = bits_q;
    if (load_i) begin
      frame_d = data_i;
      bits_d  = plane(data_i, '0);
    end else if (adv_i) begin
      bits_d  = plane(frame_q, sel_i);
    end
  end

  // frame and slice registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q <= '0;
      bits_q  <= '0;
    end else begin
      frame_q <= frame_d;
      bits_q  <= bits_d;
    end
  end

  assign bits_o = bits_q;

endmodule

// File: rtl/obc_bitplane_serializer.sv
// Emits a captured frame one bit-plane per handshake, LSB first.
// Final-slice handshake may capture the next frame directly.
module obc_bitplane_serializer #(
  parameter int DATA_W = obc_pkg::DATA_W,
  parameter int N_PTS  = obc_pkg::N_PTS,
  localparam int PW    = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_PTS*DATA_W-1:0] in_data,
  output logic                    slice_valid,
  input  logic                    slice_ready,
  output logic [N_PTS-1:0]        out_bits,
  output logic                    m,
  output logic                    slice_last,
  output logic [PW-1:0]           plane_idx
);

  import obc_pkg::*;

  localparam logic [PW-1:0] P_LAST = PW'(DATA_W - 1);

  state_e        state_q;
  logic [PW-1:0] p_q, p_d;
  logic          m_q, last_q;
  logic          p_last, hs, cap, adv, nlast;

  // handshakes and next plane index
  always_comb begin
    p_last   = (p_q == P_LAST);
    hs       = (state_q == SHIFT) && slice_ready;
    in_ready = (state_q == IDLE) || (p_last && hs);
    cap      = in_valid && in_ready;
    adv      = hs && !p_last;
    p_d      = p_q;
    if (cap)
      p_d = '0;
    else if (adv)
      p_d = p_q + 1'b1;
    nlast    = (p_d == P_LAST);
  end

  // control FSM with registered slice flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      m_q     <= 1'b0;
      last_q  <= 1'b0;
    end else if (cap || adv) begin
      state_q <= SHIFT;
      p_q     <= p_d;
      m_q     <= nlast;
      last_q  <= nlast;
    end else if (hs) begin
      state_q <= IDLE;
      p_q     <= '0;
      m_q     <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  obc_bitplane_shreg #(
    .DATA_W (DATA_W),
    .N_PTS  (N_PTS),
    .PW     (PW)
  ) u_shreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cap),
    .data_i (in_data),
    .adv_i  (adv),
    .sel_i  (p_d),
    .bits_o (out_bits)
  );

  assign slice_valid = (state_q == SHIFT);
  assign m           = m_q;
  assign slice_last  = last_q;
  assign plane_idx   = p_q;

endmodule

// File: tb/tb_obc_bitplane_serializer.sv
// Self-checking bench for obc_bitplane_serializer.
// Expected slices come from a per-sample shift-and-mask model.
module tb_obc_bitplane_serializer;

  localparam int DW = 16;
  localparam int NP = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [NP*DW-1:0] in_data;
  logic             slice_valid;
  logic             slice_ready;
  logic [NP-1:0]    out_bits;
  logic             m;
  logic             slice_last;
  logic [3:0]       plane_idx;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  obc_bitplane_serializer #(.DATA_W(DW), .N_PTS(NP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .slice_valid (slice_valid),
    .slice_ready (slice_ready),
    .out_bits    (out_bits),
    .m           (m),
    .slice_last  (slice_last),
    .plane_idx   (plane_idx)
  );

  always #5 clk = ~clk;

  // model: bit k of plane p is bit p of sample k
  function automatic logic [NP-1:0] ref_plane(
    input logic [NP*DW-1:0] f, input int p);
    logic [NP-1:0] b;
    int unsigned   s;
    for (int k = 0; k < NP; k++) begin
      s    = int'(f[k*DW +: DW]);
      b[k] = ((s >> p) % 2) == 1;
    end
    return b;
  endfunction

  function automatic logic [22:0] ref_slice(
    input logic [NP*DW-1:0] f, input int p);
    logic t;
    t = (p == DW - 1);
    return {1'b1, ref_plane(f, p), t, t, 4'(p)};
  endfunction

  function automatic logic [NP*DW-1:0] rnd_frame();
    logic [NP*DW-1:0] f;
    for (int k = 0; k < NP; k++)
      f[k*DW +: DW] = DW'($urandom);
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [NP*DW-1:0] f);
    in_valid = 1'b1;
    in_data  = f;
    tick();
    in_valid = 1'b0;
    in_data  = rnd_frame();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    chk_cnt++;
    if ({slice_valid, out_bits, m, slice_last, plane_idx, in_ready}
        !== {1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1}) begin
      $display("FAIL reset_state got v=%b b=%h m=%b l=%b p=%0d r=%b",
               slice_valid, out_bits, m, slice_last, plane_idx, in_ready);
    end else pass_cnt++;
    rst_n = 1'b1;
    tick();
    chk_cnt++;
    if ({slice_valid, in_ready} !== 2'b01)
      $display("FAIL reset_release got v=%b r=%b want v=0 r=1",
               slice_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_ramp();
    logic [NP*DW-1:0] f;
    for (int k = 0; k < NP; k++) f[k*DW +: DW] = DW'(k);
    slice_ready = 1'b1;
    load(f);
    for (int p = 0; p < DW; p++) begin
      chk_cnt++;
      if ({slice_valid, out_bits, m, slice_last, plane_idx}
          !== ref_slice(f, p))
        $display("FAIL ramp_p%0d got %h want %h", p,
                 {slice_valid, out_bits, m, slice_last, plane_idx},
                 ref_slice(f, p));
      else pass_cnt++;
      if (p == 0) begin
        chk_cnt++;
        if (out_bits !== 16'hAAAA)
          $display("FAIL ramp_plane0 got %h want aaaa", out_bits);
        else pass_cnt++;
      end
      if (p == 1) begin
        chk_cnt++;
        if (out_bits !== 16'hCCCC)
          $display("FAIL ramp_plane1 got %h want cccc", out_bits);
        else pass_cnt++;
      end
      tick();
    end
    chk_cnt++;
    if (slice_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL ramp_idle got v=%b r=%b want v=0 r=1",
               slice_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_min();
    logic [NP*DW-1:0] f;
    for (int k = 0; k < NP; k++) f[k*DW +: DW] = 16'h8000;
    slice_ready = 1'b1;
    load(f);
    for (int p = 0; p < DW; p++) begin
      chk_cnt++;
      if ({slice_valid, out_bits, m, slice_last, plane_idx}
          !== ref_slice(f, p))
        $display("FAIL min_p%0d got %h want %h", p,
                 {slice_valid, out_bits, m, slice_last, plane_idx},
                 ref_slice(f, p));
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_stall();
    logic [NP*DW-1:0] f;
    f = rnd_frame();
    slice_ready = 1'b1;
    load(f);
    for (int p = 0; p < DW; p++) begin
      if (p == 3) begin
        slice_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          chk_cnt++;
          if ({slice_valid, out_bits, m, slice_last, plane_idx, in_ready}
              !== {ref_slice(f, 3), 1'b0})
            $display("FAIL stall_c%0d got %h want %h", c,
                     {slice_valid, out_bits, m, slice_last, plane_idx},
                     ref_slice(f, 3));
          else pass_cnt++;
          tick();
        end
        slice_ready = 1'b1;
      end
      chk_cnt++;
      if ({slice_valid, out_bits, m, slice_last, plane_idx}
          !== ref_slice(f, p))
        $display("FAIL stall_p%0d got %h want %h", p,
                 {slice_valid, out_bits, m, slice_last, plane_idx},
                 ref_slice(f, p));
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [NP*DW-1:0] fa, fb;
    fa = rnd_frame();
    fb = rnd_frame();
    slice_ready = 1'b1;
    load(fa);
    for (int p = 0; p < DW; p++) begin
      if (p == DW - 1) begin
        in_valid = 1'b1;
        in_data  = fb;
      end
      #1;
      chk_cnt++;
      if (in_ready !== (p == DW - 1))
        $display("FAIL b2b_ready_p%0d got %b want %b", p,
                 in_ready, (p == DW - 1));
      else pass_cnt++;
      chk_cnt++;
      if ({slice_valid, out_bits, m, slice_last, plane_idx}
          !== ref_slice(fa, p))
        $display("FAIL b2b_a_p%0d got %h want %h", p,
                 {slice_valid, out_bits, m, slice_last, plane_idx},
                 ref_slice(fa, p));
      else pass_cnt++;
      tick();
    end
    in_valid = 1'b0;
    in_data  = rnd_frame();
    for (int p = 0; p < DW; p++) begin
      chk_cnt++;
      if ({slice_valid, out_bits, m, slice_last, plane_idx}
          !== ref_slice(fb, p))
        $display("FAIL b2b_b_p%0d got %h want %h", p,
                 {slice_valid, out_bits, m, slice_last, plane_idx},
                 ref_slice(fb, p));
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [NP*DW-1:0] f;
    f = rnd_frame();
    slice_ready = 1'b1;
    load(f);
    for (int p = 0; p < 7; p++) tick();
    chk_cnt++;
    if (plane_idx !== 4'd7)
      $display("FAIL rstmid_pre got p=%0d want 7", plane_idx);
    else pass_cnt++;
    rst_n = 1'b0;
    tick();
    chk_cnt++;
    if ({slice_valid, out_bits, plane_idx, m, slice_last}
        !== {1'b0, 16'h0, 4'h0, 2'b00})
      $display("FAIL rstmid_in_reset got v=%b b=%h p=%0d",
               slice_valid, out_bits, plane_idx);
    else pass_cnt++;
    rst_n = 1'b1;
    chk_cnt++;
    if ({slice_valid, in_ready} !== 2'b01)
      $display("FAIL rstmid_after got v=%b r=%b want v=0 r=1",
               slice_valid, in_ready);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (slice_valid !== 1'b0)
      $display("FAIL rstmid_no_p8 got v=%b want 0", slice_valid);
    else pass_cnt++;
    f = rnd_frame();
    load(f);
    for (int p = 0; p < DW; p++) begin
      chk_cnt++;
      if ({slice_valid, out_bits, m, slice_last, plane_idx}
          !== ref_slice(f, p))
        $display("FAIL rstmid_new_p%0d got %h want %h", p,
                 {slice_valid, out_bits, m, slice_last, plane_idx},
                 ref_slice(f, p));
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_data_change();
    logic [NP*DW-1:0] f;
    f = rnd_frame();
    slice_ready = 1'b1;
    load(f);
    for (int p = 0; p < DW; p++) begin
      in_data = rnd_frame();
      chk_cnt++;
      if ({slice_valid, out_bits, m, slice_last, plane_idx}
          !== ref_slice(f, p))
        $display("FAIL dchg_p%0d got %h want %h", p,
                 {slice_valid, out_bits, m, slice_last, plane_idx},
                 ref_slice(f, p));
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_random();
    logic [NP*DW-1:0] f;
    int               p;
    int               cyc;
    logic             rdy;
    for (int n = 0; n < 6; n++) begin
      f = rnd_frame();
      slice_ready = 1'b0;
      load(f);
      p   = 0;
      cyc = 0;
      while (p < DW && cyc < 200) begin
        rdy         = ($urandom % 3) != 0;
        slice_ready = rdy;
        in_data     = rnd_frame();
        chk_cnt++;
        if ({slice_valid, out_bits, m, slice_last, plane_idx}
            !== ref_slice(f, p))
          $display("FAIL rand_f%0d_p%0d got %h want %h", n, p,
                   {slice_valid, out_bits, m, slice_last, plane_idx},
                   ref_slice(f, p));
        else pass_cnt++;
        tick();
        if (rdy) p++;
        cyc++;
      end
      chk_cnt++;
      if (p != DW || slice_valid !== 1'b0)
        $display("FAIL rand_f%0d_end got p=%0d v=%b want p=16 v=0",
                 n, p, slice_valid);
      else pass_cnt++;
    end
    slice_ready = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    slice_ready = 1'b0;
    test_reset();
    test_ramp();
    test_min();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_data_change();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
